// File: rtl/router_fifo_if.sv
// Handshake/data bundle between a router sync stage / output port and one
// router_fifo instance.
//   write_enb : write request into the FIFO
//   read_enb  : read request from the output port
//   lfd_state : tags the byte being written as a packet header
//   data_in   : write data
//   data_out  : registered read data
//   full      : FIFO full
//   empty     : FIFO empty
// master = requester side (sync stage / output port), slave = the FIFO.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty
  );
endinterface

// File: rtl/router_fifo.sv
// Router packet FIFO. Each entry holds a data byte plus a header tag
// (lfd_state at write time). Reading a tagged entry loads a packet counter
// with the packet's remaining length (payload + parity); data_out is zeroed
// on idle cycles once the packet is complete.
// Ports:
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   soft_reset : synchronous flush, overrides reads and writes
//   bus        : router_fifo_if.slave (write_enb, read_enb, lfd_state,
//                data_in, data_out, full, empty)
//   err        : sticky overflow/underflow flag, only when the macro
//                ROUTER_FIFO_ERR_EN is defined (absent otherwise)
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         soft_reset,
  router_fifo_if.slave bus
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic         err
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  // Header byte bits [WIDTH-1:2] carry the payload length; +1 covers parity.
  function automatic logic [6:0] hdr_len(input logic [WIDTH-1:0] d);
    return 7'(d[WIDTH-1:2]) + 7'd1;
  endfunction

  logic [WIDTH:0]   mem_q [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [6:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic [WIDTH:0]   rd_ent;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign wr_acc = bus.write_enb && !full;
  assign rd_acc = bus.read_enb && !empty;
  assign rd_ent = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.data_out = data_out_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + ptr_t'(1);
        data_out_d = rd_ent[WIDTH-1:0];
        if (rd_ent[WIDTH]) begin
          pkt_cnt_d = hdr_len(rd_ent[WIDTH-1:0]);
        end else if (pkt_cnt_q != 7'd0) begin
          pkt_cnt_d = pkt_cnt_q - 7'd1;
        end
      end else if (pkt_cnt_q == 7'd0) begin
        // Packet finished and no read: drive the idle value.
        data_out_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is not reset; a flush only moves the pointers.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (soft_reset) begin
      err_d = 1'b0;
    end else if ((bus.write_enb && full) || (bus.read_enb && empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic       lfd;
    logic [7:0] d;
  } ent_t;

  logic clock = 1'b0;
  logic reset;
  logic soft_reset;

  router_fifo_if #(.WIDTH(WIDTH)) bus ();

`ifdef ROUTER_FIFO_ERR_EN
  logic err;
`endif

  router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
`ifdef ROUTER_FIFO_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clock = ~clock;

  // Reference model state
  ent_t       mq[$];
  int         m_cnt;
  logic [7:0] m_dout;
  bit         m_err;

  int    n_cmp;
  int    n_bad;
  string phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then compare.
  task automatic cycle(input bit rst, input bit sr, input bit we, input bit re,
                       input bit lfd, input logic [7:0] din);
    bit   m_full, m_empty, rd, wr;
    ent_t e;
    reset         = rst;
    soft_reset    = sr;
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    if (rst || sr) begin
      mq.delete();
      m_cnt  = 0;
      m_dout = 8'h00;
      m_err  = 1'b0;
    end else begin
      if ((we && m_full) || (re && m_empty)) m_err = 1'b1;
      rd = re && !m_empty;
      wr = we && !m_full;
      if (rd) begin
        e      = mq.pop_front();
        m_dout = e.d;
        if (e.lfd) m_cnt = int'(e.d[7:2]) + 1;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (wr) begin
        e.lfd = lfd;
        e.d   = din;
        mq.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    chk("data_out", 32'(bus.data_out), 32'(m_dout));
    chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("pkt_cnt", 32'(dut.pkt_cnt_q), 32'(m_cnt));
`ifdef ROUTER_FIFO_ERR_EN
    chk("err", 32'(err), 32'(m_err));
`endif
  endtask

  initial begin
    logic [7:0] pkt[5];
    n_cmp = 0;
    n_bad = 0;
    m_cnt = 0;
    m_dout = 8'h00;
    m_err = 1'b0;
    reset = 1'b1;
    soft_reset = 1'b0;
    bus.write_enb = 1'b0;
    bus.read_enb = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in = 8'h00;

    phase = "reset";
    cycle(1, 0, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 0, 8'h00);
    chk("empty_lit", 32'(bus.empty), 32'd1);
    chk("full_lit", 32'(bus.full), 32'd0);
    chk("dout_lit", 32'(bus.data_out), 32'd0);

    phase = "pkt";
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, (i == 0), pkt[i]);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 0, 8'h00);
      chk("dout_lit", 32'(bus.data_out), 32'(pkt[i]));
      chk("cnt_lit", 32'(dut.pkt_cnt_q), 32'(4 - i));
    end
    cycle(0, 0, 0, 0, 0, 8'h00);
    chk("idle_dout_lit", 32'(bus.data_out), 32'd0);
    chk("idle_empty_lit", 32'(bus.empty), 32'd1);

    phase = "fill";
    for (int i = 0; i < 17; i++) begin
      cycle(0, 0, 1, 0, 0, 8'(i + 1));
      if (i == 15) chk("full16_lit", 32'(bus.full), 32'd1);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 1, 0, 8'h00);
      chk("rd_lit", 32'(bus.data_out), 32'(i + 1));
    end
    chk("drained_lit", 32'(bus.empty), 32'd1);

    phase = "simul";
    cycle(0, 0, 1, 1, 0, 8'hA0);
    chk("occ0_empty_lit", 32'(bus.empty), 32'd0);
    for (int i = 1; i < 8; i++) cycle(0, 0, 1, 0, 0, 8'(8'hA0 + i));
    cycle(0, 0, 1, 1, 0, 8'hB8);
    chk("occ8_lit", 32'(mq.size()), 32'd8);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, 8'(8'hC0 + i));
    chk("occ16_full_lit", 32'(bus.full), 32'd1);
    cycle(0, 0, 1, 1, 0, 8'hEE);
    chk("occ16_rdonly_lit", 32'(bus.full), 32'd0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 1, 0, 8'h00);
    chk("simul_drained_lit", 32'(bus.empty), 32'd1);

    phase = "soft";
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, (i == 0), 8'(8'h50 + i));
    cycle(0, 0, 0, 1, 0, 8'h00);
    cycle(0, 1, 1, 0, 0, 8'h77);
    chk("empty_lit", 32'(bus.empty), 32'd1);
    chk("full_lit", 32'(bus.full), 32'd0);
    chk("dout_lit", 32'(bus.data_out), 32'd0);
    cycle(0, 0, 0, 1, 0, 8'h00);
    chk("lost_write_lit", 32'(bus.data_out), 32'd0);

    phase = "wrap";
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 1, 0, 0, 8'($urandom));
      cycle(0, 0, 0, 1, 0, 8'h00);
    end

    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      bit we, re;
      if (i < 200) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 2) == 0);
      end else begin
        we = ($urandom_range(0, 2) == 0);
        re = ($urandom_range(0, 3) != 0);
      end
      cycle(0, ($urandom_range(0, 59) == 0), we, re,
            ($urandom_range(0, 7) == 0), 8'($urandom));
    end

`ifdef ROUTER_FIFO_ERR_EN
    phase = "err";
    cycle(1, 0, 0, 0, 0, 8'h00);
    chk("clear_lit", 32'(err), 32'd0);
    cycle(0, 0, 0, 1, 0, 8'h00);
    chk("set_lit", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0, 8'(i));
      chk("hold_lit", 32'(err), 32'd1);
    end
    cycle(0, 1, 0, 0, 0, 8'h00);
    chk("soft_clr_lit", 32'(err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
